// File: rtl/sdram_nbank.sv
// Behavioural multi-bank SDRAM model: per-bank open-row tracking, sequential-wrap
// bursts, CAS latency on reads, and a sticky protocol-error flag.
module sdram_nbank_bank #(
  parameter int ROW_BITS = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                act_i,
  input  logic                pre_i,
  input  logic [ROW_BITS-1:0] row_i,
  output logic                open_o,
  output logic [ROW_BITS-1:0] row_o
);
  logic                open_q;
  logic [ROW_BITS-1:0] row_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      open_q <= 1'b0;
      row_q  <= '0;
    end else if (act_i) begin
      open_q <= 1'b1;
      row_q  <= row_i;
    end else if (pre_i) begin
      open_q <= 1'b0;
    end
  end

  assign open_o = open_q;
  assign row_o  = row_q;
endmodule

module sdram_nbank #(
  parameter int DW       = 8,
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4,
  parameter int BA_BITS  = 1,
  parameter int CL       = 2,
  parameter int BL       = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CS,
  input  logic                RAS,
  input  logic                CAS,
  input  logic                WE,
  input  logic [BA_BITS-1:0]  BA,
  input  logic [ROW_BITS-1:0] A,
  input  logic [DW-1:0]       DQ_IN,
  output logic [DW-1:0]       DQ_OUT,
  output logic                DQ_OE,
  output logic                BUSY,
  output logic                ERR
);
  localparam int NB = 1 << BA_BITS;
  localparam int CW = $clog2(BL) + 1;
  localparam int AW = BA_BITS + ROW_BITS + COL_BITS;
  localparam logic [CW-1:0] BL_C  = CW'(BL);
  localparam logic [CW-1:0] BL_M1 = CW'(BL - 1);
  localparam logic [1:0]    WAIT0 = (CL > 1) ? 2'(CL - 2) : 2'd0;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

  typedef struct packed {
    logic [BA_BITS-1:0]  ba;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] c0;
  } burst_t;

  state_t          state_q, state_d;
  burst_t          bst_q, bst_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [1:0]      wait_q, wait_d;
  logic            oe_q, oe_d;
  logic            err_q;
  logic [DW-1:0]   dq_q;
  logic            rd_beat, mem_we;
  logic [AW-1:0]   mem_waddr, burst_addr;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  logic [NB-1:0]               bank_open;
  logic [NB-1:0][ROW_BITS-1:0] bank_row;

  logic [2:0] cmd;
  logic is_act, is_rd, is_wr, is_pre, sel_open, busy;
  logic act_ok, rd_ok, wr_ok, pre_ok, err_set;

  assign cmd    = CS ? {RAS, CAS, WE} : 3'b000;
  assign is_act = (cmd == 3'b100);
  assign is_rd  = (cmd == 3'b010);
  assign is_wr  = (cmd == 3'b011);
  assign is_pre = (cmd == 3'b101);

  assign sel_open = bank_open[BA];
  assign busy     = (state_q != IDLE);

  // ACTIVE may overlap a burst as long as the target bank is closed.
  assign act_ok  = is_act && !sel_open;
  assign rd_ok   = is_rd && sel_open && !busy;
  assign wr_ok   = is_wr && sel_open && !busy;
  assign pre_ok  = is_pre && !busy;
  assign err_set = (is_act && sel_open) || ((is_rd || is_wr) && (busy || !sel_open)) ||
                   (is_pre && busy);

  for (genvar b = 0; b < NB; b++) begin : g_bank
    sdram_nbank_bank #(.ROW_BITS(ROW_BITS)) u_bank (
      .CLK   (CLK),
      .RST_N (RST_N),
      .act_i (act_ok && (BA == BA_BITS'(b))),
      .pre_i (pre_ok && (BA == BA_BITS'(b))),
      .row_i (A),
      .open_o(bank_open[b]),
      .row_o (bank_row[b])
    );
  end

  // Sequential wrap inside the BL-aligned column block.
  function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] c0,
                                                   input logic [CW-1:0] i);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(BL - 1);
    return (c0 & ~m) | ((c0 + COL_BITS'(i)) & m);
  endfunction

  assign burst_addr = {bst_q.ba, bst_q.row, beat_col(bst_q.c0, beat_q)};

  always_comb begin
    state_d   = state_q;
    bst_d     = bst_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    oe_d      = 1'b0;
    rd_beat   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = burst_addr;
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = {BA, bank_row[BA], A[COL_BITS-1:0]};
          bst_d     = '{ba: BA, row: bank_row[BA], c0: A[COL_BITS-1:0]};
          if (BL > 1) begin
            beat_d  = CW'(1);
            state_d = WR_BURST;
          end
        end else if (rd_ok) begin
          bst_d   = '{ba: BA, row: bank_row[BA], c0: A[COL_BITS-1:0]};
          beat_d  = '0;
          wait_d  = WAIT0;
          state_d = (CL == 1) ? RD_BURST : RD_WAIT;
        end
      end
      WR_BURST: begin
        mem_we = 1'b1;
        beat_d = beat_q + CW'(1);
        if (beat_q == BL_M1) begin
          beat_d  = '0;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (wait_q == 2'd0) state_d = RD_BURST;
        else                wait_d  = wait_q - 2'd1;
      end
      RD_BURST: begin
        // One extra cycle after the last beat drops DQ_OE and returns to IDLE.
        if (beat_q == BL_C) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          oe_d    = 1'b1;
          rd_beat = 1'b1;
          beat_d  = beat_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      bst_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      oe_q    <= 1'b0;
      dq_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bst_q   <= bst_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      oe_q    <= oe_d;
      if (rd_beat) dq_q <= mem[burst_addr];
      if (err_set) err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= DQ_IN;
  end

  assign DQ_OUT = dq_q;
  assign DQ_OE  = oe_q;
  assign BUSY   = busy;
  assign ERR    = err_q;
endmodule

// File: tb/tb_sdram_nbank.sv
// Directed bench for sdram_nbank at default parameters (CL=2, BL=4).
module tb_sdram_nbank;
  localparam int DW = 8, ROW_BITS = 4, COL_BITS = 4, BA_BITS = 1, CL = 2, BL = 4;
  localparam logic [2:0] ACT = 3'b100, RD = 3'b010, WR = 3'b011, PRE = 3'b101;

  logic                CLK = 1'b0, RST_N = 1'b0, CS = 1'b0;
  logic                RAS = 1'b0, CAS = 1'b0, WE = 1'b0;
  logic [BA_BITS-1:0]  BA = '0;
  logic [ROW_BITS-1:0] A = '0;
  logic [DW-1:0]       DQ_IN = '0;
  logic [DW-1:0]       DQ_OUT;
  logic                DQ_OE, BUSY, ERR;
  int n_run = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  sdram_nbank #(.DW(DW), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BA_BITS(BA_BITS),
                .CL(CL), .BL(BL)) dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .BA(BA), .A(A), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE),
    .BUSY(BUSY), .ERR(ERR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [BA_BITS-1:0] b,
                       input logic [ROW_BITS-1:0] a, input logic [DW-1:0] d);
    CS = 1'b1; {RAS, CAS, WE} = c; BA = b; A = a; DQ_IN = d;
  endtask

  task automatic nop;
    CS = 1'b0; {RAS, CAS, WE} = 3'b000;
  endtask

  task automatic issue(input logic [2:0] c, input logic [BA_BITS-1:0] b,
                       input logic [ROW_BITS-1:0] a);
    drive(c, b, a, '0);
    tick;
    nop;
  endtask

  task automatic do_reset;
    #2 RST_N = 1'b0;
    #1;
    chk("rst_dq",   32'(DQ_OUT), 32'h0);
    chk("rst_oe",   32'(DQ_OE),  32'h0);
    chk("rst_busy", 32'(BUSY),   32'h0);
    chk("rst_err",  32'(ERR),    32'h0);
    tick;
    #2 RST_N = 1'b1;
  endtask

  task automatic wr4(input logic [BA_BITS-1:0] b, input logic [ROW_BITS-1:0] col,
                     input logic [DW-1:0] d0, d1, d2, d3);
    drive(WR, b, col, d0);
    tick;
    nop;
    chk("wr_busy", 32'(BUSY), 32'h1);
    DQ_IN = d1; tick;
    DQ_IN = d2; tick;
    DQ_IN = d3; tick;
    chk("wr_done", 32'(BUSY), 32'h0);
  endtask

  // exp packs beats as {beat0, beat1, beat2, beat3}; inj 1 = WRITE, 2 = ACTIVE bank 1,
  // both issued one cycle after the READ.
  task automatic rd4(input string tag, input logic [BA_BITS-1:0] b,
                     input logic [ROW_BITS-1:0] col, input logic [31:0] exp, input int inj);
    drive(RD, b, col, '0);
    tick;
    nop;
    chk({tag, "_oe_k"},  32'(DQ_OE), 32'h0);
    chk({tag, "_busy"},  32'(BUSY),  32'h1);
    if (inj == 1) drive(WR, 1'b0, 4'd0, 8'hFF);
    else if (inj == 2) drive(ACT, 1'b1, 4'd5, 8'h00);
    tick;
    nop;
    chk({tag, "_oe_k1"}, 32'(DQ_OE), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("%s_oe%0d", tag, i), 32'(DQ_OE), 32'h1);
      chk($sformatf("%s_dq%0d", tag, i), 32'(DQ_OUT), 32'(exp[(3-i)*8 +: 8]));
    end
    tick;
    chk({tag, "_oe_end"},   32'(DQ_OE),  32'h0);
    chk({tag, "_busy_end"}, 32'(BUSY),   32'h0);
    chk({tag, "_hold"},     32'(DQ_OUT), 32'(exp[7:0]));
  endtask

  initial begin
    do_reset;

    // Basic write then read, bank 0 row 3
    issue(ACT, 1'b0, 4'd3);
    wr4(1'b0, 4'd0, 8'h11, 8'h22, 8'h33, 8'h44);
    rd4("basic", 1'b0, 4'd0, 32'h11223344, 0);

    // Wrap inside block 4..7
    wr4(1'b0, 4'd6, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    rd4("wrap", 1'b0, 4'd4, 32'hA2A3A0A1, 0);
    chk("wrap_err", 32'(ERR), 32'h0);

    // Read of a never-activated bank
    issue(RD, 1'b1, 4'd0);
    chk("closed_err",  32'(ERR),  32'h1);
    chk("closed_busy", 32'(BUSY), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("closed_oe%0d", i), 32'(DQ_OE), 32'h0);
    end

    // WRITE during a read burst is dropped
    do_reset;
    issue(ACT, 1'b0, 4'd3);
    rd4("wrblk", 1'b0, 4'd0, 32'h11223344, 1);
    chk("wrblk_err", 32'(ERR), 32'h1);

    // ACTIVE to closed bank 1 during a bank-0 read is accepted
    do_reset;
    issue(ACT, 1'b0, 4'd3);
    rd4("actov", 1'b0, 4'd0, 32'h11223344, 2);
    chk("actov_err", 32'(ERR), 32'h0);
    wr4(1'b1, 4'd8, 8'h05, 8'h06, 8'h07, 8'h08);
    rd4("bank1", 1'b1, 4'd9, 32'h06070805, 0);
    chk("bank1_err", 32'(ERR), 32'h0);

    // PRECHARGE closed bank is fine; double ACTIVE is an error
    do_reset;
    issue(PRE, 1'b1, 4'd0);
    chk("pre_closed_err", 32'(ERR), 32'h0);
    issue(ACT, 1'b0, 4'd3);
    chk("act1_err", 32'(ERR), 32'h0);
    issue(ACT, 1'b0, 4'd3);
    chk("act2_err", 32'(ERR), 32'h1);

    // Reset during beat 2 of a write
    do_reset;
    issue(ACT, 1'b0, 4'd3);
    rd4("pre_rst", 1'b0, 4'd0, 32'h11223344, 0);
    drive(WR, 1'b0, 4'd0, 8'h55);
    tick;
    nop;
    DQ_IN = 8'h66; tick;
    DQ_IN = 8'h77;
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_dq",   32'(DQ_OUT), 32'h0);
    chk("midrst_oe",   32'(DQ_OE),  32'h0);
    chk("midrst_busy", 32'(BUSY),   32'h0);
    tick;
    DQ_IN = 8'h88;
    tick;
    #2 RST_N = 1'b1;
    issue(RD, 1'b0, 4'd0);
    chk("midrst_closed_err",  32'(ERR),  32'h1);
    chk("midrst_closed_busy", 32'(BUSY), 32'h0);
    do_reset;
    issue(ACT, 1'b0, 4'd3);
    rd4("post_rst", 1'b0, 4'd0, 32'h55663344, 0);
    chk("post_rst_err", 32'(ERR), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_nbank.md
SDRAM_NBANK -- requirements
Module: sdram_nbank

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter ROW_BITS, default 4, row address bits per bank.
REQ-003 Parameter COL_BITS, default 4, column address bits; COL_BITS <= ROW_BITS.
REQ-004 Parameter BA_BITS, default 1, bank address bits (2**BA_BITS banks).
REQ-005 Parameter CL, default 2, CAS read latency in cycles; legal 1..3.
REQ-006 Parameter BL, default 4, burst length; legal 1, 2, 4, 8.
REQ-007 CLK  input  1  sole clock; all state changes on rising edge.
REQ-008 RST_N  input  1  reset, asynchronous, active-low.
REQ-009 CS  input  1  chip select, active-high; CS=0 means NOP.
REQ-010 RAS, CAS, WE  input  1 each  command strobes, active-high.
REQ-011 BA  input  BA_BITS  bank address.
REQ-012 A  input  ROW_BITS  row address (ACTIVE) or column in A[COL_BITS-1:0] (READ/WRITE).
REQ-013 DQ_IN  input  DW  write data.
REQ-014 DQ_OUT  output  DW  read data, registered.
REQ-015 DQ_OE  output  1  high while DQ_OUT carries a valid read beat.
REQ-016 BUSY  output  1  high while a burst is in progress.
REQ-017 ERR  output  1  sticky protocol-error flag.

Function
REQ-018 Commands decode on each rising edge with CS=1 as {RAS,CAS,WE}: 100 ACTIVE, 010 READ, 011 WRITE, 101 PRECHARGE; all other codes are NOP.
REQ-019 Storage: 2**BA_BITS x 2**ROW_BITS x 2**COL_BITS words of DW bits; contents are not reset.
REQ-020 Per bank: open flag plus open-row register; ACTIVE sets them, PRECHARGE clears open flag.
REQ-021 ACTIVE to an already-open bank: ignored, ERR set.
REQ-022 PRECHARGE to a closed bank: legal no-op, no ERR.
REQ-023 READ/WRITE to a closed bank: ignored, ERR set, no state change.
REQ-024 READ, WRITE or PRECHARGE while BUSY=1: ignored, ERR set; ACTIVE to a different, closed bank while BUSY=1 is legal.
REQ-025 Burst addressing: beat i uses column (c0 & ~(BL-1)) | ((c0 + i) mod BL), i.e. sequential wrap inside the BL-aligned block.
REQ-026 FSM states: IDLE, WR_BURST, RD_WAIT, RD_BURST; reset and all ignored commands leave/keep IDLE.
REQ-027 IDLE -> WR_BURST on valid WRITE when BL>1; a valid WRITE with BL=1 stays in IDLE.
REQ-028 WRITE sampled at edge k: beat 0 = DQ_IN at edge k; beat i at edge k+i; WR_BURST -> IDLE after edge k+BL-1.
REQ-029 IDLE -> RD_WAIT on valid READ at edge k (or directly to RD_BURST when CL=1); RD_WAIT counts CL-1 cycles, then RD_BURST.
REQ-030 READ at edge k: beat i registered onto DQ_OUT at edge k+CL+i with DQ_OE=1; after edge k+CL+BL, DQ_OE=0 and state IDLE.
REQ-031 BUSY=1 in every state except IDLE (combinational from state).
REQ-032 DQ_OUT holds its last value when DQ_OE=0.
REQ-033 Read of a word written earlier returns the written data; a read of a never-written word returns unspecified data.
REQ-034 ERR stays set until reset; no other clear mechanism.
REQ-035 All width arithmetic on column offsets is modulo 2**COL_BITS; no overflow into row or bank.

Reset
REQ-036 RST_N=0 immediately forces: state IDLE, all banks closed, DQ_OUT=0, DQ_OE=0, BUSY=0, ERR=0, burst counters 0.
REQ-037 Reset asserted mid-burst aborts the burst; words already written remain, remaining beats are not written.
REQ-038 First command is sampled on the first rising edge after RST_N rises.

Verification
REQ-039 Defaults: ACTIVE BA=0 A=3; WRITE col 0 with DQ_IN 11,22,33,44 on 4 edges; READ col 0 -> DQ_OE high 2 cycles later, DQ_OUT 11,22,33,44.
REQ-040 WRITE col 6 data A0,A1,A2,A3; READ col 4 -> A2,A3,A0,A1 (wrap inside block 4..7).
REQ-041 READ to bank 1 never activated -> no DQ_OE, ERR=1, BUSY stays 0.
REQ-042 WRITE issued while a READ burst is active -> ignored, ERR=1, read burst completes unchanged.
REQ-043 ACTIVE bank 1 during bank-0 read burst -> accepted, no ERR; subsequent WRITE/READ to bank 1 works.
REQ-044 RST_N pulsed low during beat 2 of a 4-beat write -> outputs zero at once, banks closed; after re-ACTIVE, read returns beats 0-1 new, beats 2-3 old data.
